uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_os_tick.sv | 34 +++
 rtl/uart_rx_core.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM states, parity type, error flag layout.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_typ_e;

  localparam int unsigned ERR_PAR = 0;
  localparam int unsigned ERR_STP = 1;
  localparam int unsigned ERR_OVR = 2;
  localparam int unsigned ERR_W   = 3;

  // Majority vote used for every received bit.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-clock pulse every max(i_prescale,1) clocks, restartable.
module uart_os_tick #(
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_restart,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_cnt;
  logic [PRESCALE_W-1:0] w_last;

  // A prescale of zero behaves like one: tick every clock.
  assign w_last = (i_prescale == '0) ? '0 : i_prescale - PRESCALE_W'(1);

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_cnt  <= '0;
      o_tick <= 1'b0;
    end else if (i_restart) begin
      r_cnt  <= '0;
      o_tick <= 1'b0;
    end else if (r_cnt >= w_last) begin
      r_cnt  <= '0;
      o_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + PRESCALE_W'(1);
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronised line, 3-sample majority per bit, optional parity and second stop bit,
// single-entry output register with ready handshake and overrun flag.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OS_RATE    = 16,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_rx_in,
  input  logic [PRESCALE_W-1:0] i_prescale,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  input  logic                  i_stop2,
  input  logic                  i_ready,
  output logic [DATA_W-1:0]     o_data,
  output logic                  o_valid,
  output logic [ERR_W-1:0]      o_error_flag,
  output logic                  o_active_flag
);

  localparam int unsigned OS_W  = $clog2(OS_RATE);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam logic [OS_W-1:0] SMP_A   = OS_W'(OS_RATE / 2 - 1);
  localparam logic [OS_W-1:0] SMP_B   = OS_W'(OS_RATE / 2);
  localparam logic [OS_W-1:0] SMP_C   = OS_W'(OS_RATE / 2 + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);

  logic                  r_sync1, r_sync2, r_rx_prev;
  rx_state_e             r_state, w_state_nxt;
  logic                  r_active;
  logic [OS_W-1:0]       r_os_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [1:0]            r_smp;
  logic [DATA_W-1:0]     r_shift;
  logic                  r_par_err, r_stp_err;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_par_en, r_stop2;
  par_typ_e              r_par_typ;
  logic                  w_tick;
  logic                  w_start_c, w_bit_end_c, w_maj_c, w_load_c;

  uart_os_tick #(.PRESCALE_W(PRESCALE_W)) u_tick (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .i_restart  (w_start_c),
    .i_prescale (r_prescale),
    .o_tick     (w_tick)
  );

  // Two-flop synchroniser plus one history flop for edge detection; idle-high after reset.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= i_rx_in;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state  <= ST_IDLE;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= (w_state_nxt != ST_IDLE);
    end
  end

  // Bit decisions happen on the third sample; the frame ends mid-way through the last stop bit.
  always_comb begin
    w_state_nxt = r_state;
    w_start_c   = 1'b0;
    w_load_c    = 1'b0;
    w_bit_end_c = w_tick && (r_os_cnt == SMP_C);
    w_maj_c     = maj3(r_smp[0], r_smp[1], r_sync2);
    unique case (r_state)
      ST_IDLE: begin
        if (r_rx_prev && !r_sync2) begin
          w_start_c   = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_end_c) w_state_nxt = w_maj_c ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_bit_end_c && (r_bit_cnt == BIT_W'(DATA_W - 1)))
          w_state_nxt = r_par_en ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: begin
        if (w_bit_end_c) w_state_nxt = ST_STOP1;
      end
      ST_STOP1: begin
        if (w_bit_end_c) begin
          if (r_stop2) begin
            w_state_nxt = ST_STOP2;
          end else begin
            w_state_nxt = ST_IDLE;
            w_load_c    = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (w_bit_end_c) begin
          w_state_nxt = ST_IDLE;
          w_load_c    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame datapath: config latch, oversample position, sample capture, shift and error accumulation.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_os_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_smp      <= '0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_stp_err  <= 1'b0;
      r_prescale <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= PAR_EVEN;
      r_stop2    <= 1'b0;
    end else begin
      if (w_start_c) begin
        r_os_cnt   <= '0;
        r_bit_cnt  <= '0;
        r_par_err  <= 1'b0;
        r_stp_err  <= 1'b0;
        r_prescale <= i_prescale;
        r_par_en   <= i_par_en;
        r_par_typ  <= par_typ_e'(i_par_typ);
        r_stop2    <= i_stop2;
      end else if (w_tick) begin
        r_os_cnt <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_W'(1);
      end
      if (w_tick && (r_os_cnt == SMP_A)) r_smp[0] <= r_sync2;
      if (w_tick && (r_os_cnt == SMP_B)) r_smp[1] <= r_sync2;
      if (w_bit_end_c) begin
        unique case (r_state)
          ST_DATA: begin
            r_shift   <= {w_maj_c, r_shift[DATA_W-1:1]};
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          end
          ST_PARITY: r_par_err <= (^r_shift) ^ w_maj_c ^ (r_par_typ == PAR_ODD);
          ST_STOP1, ST_STOP2: begin
            if (!w_maj_c) r_stp_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Output word register; a load while the previous word is still unconsumed flags overrun.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_error_flag <= '0;
    end else if (w_load_c) begin
      o_data                <= r_shift;
      o_valid               <= 1'b1;
      o_error_flag[ERR_PAR] <= r_par_err;
      o_error_flag[ERR_STP] <= r_stp_err | ~w_maj_c;
      o_error_flag[ERR_OVR] <= o_valid & ~i_ready;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  assign o_active_flag = r_active;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int unsigned DW = 8;
  localparam int unsigned OS = 16;
  localparam int unsigned PW = 6;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          rx;
  logic [PW-1:0] prescale;
  logic          par_en, par_typ, stop2, ready;
  logic [DW-1:0] data;
  logic          valid;
  logic [2:0]    err;
  logic          active;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int unsigned stop_cyc = 0;
  logic        mon_en = 1'b0;
  logic [10:0] got_q[$];
  int unsigned got_cyc_q[$];

  uart_rx_core #(.DATA_W(DW), .OS_RATE(OS), .PRESCALE_W(PW)) dut (
    .i_clk         (clk),
    .i_arst_n      (arst_n),
    .i_rx_in       (rx),
    .i_prescale    (prescale),
    .i_par_en      (par_en),
    .i_par_typ     (par_typ),
    .i_stop2       (stop2),
    .i_ready       (ready),
    .o_data        (data),
    .o_valid       (valid),
    .o_error_flag  (err),
    .o_active_flag (active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // With ready held high every received word shows as a single valid cycle.
  always @(negedge clk) begin
    if (mon_en && valid) begin
      got_q.push_back({data, err});
      got_cyc_q.push_back(cyc);
    end
  end

  // Expected {data, overrun, stop, parity} from what was put on the line.
  function automatic logic [10:0] ref_word(input logic [7:0] d, input logic pe, input logic pt,
                                           input logic pbit, input logic s2, input logic [1:0] stops,
                                           input logic ovr);
    logic perr, serr;
    int   ones;
    ones = $countones(d) + int'(pbit);
    perr = pe && (((ones % 2) == 1) != pt);
    serr = !stops[0] || (s2 && !stops[1]);
    return {d, ovr, serr, perr};
  endfunction

  function automatic logic good_par(input logic [7:0] d, input logic pt);
    return ((($countones(d) % 2) == 1) != pt);
  endfunction

  // Drive one frame starting at the current negedge; config is scrambled mid-frame to prove it is latched.
  task automatic send_frame(input logic [7:0] d, input int unsigned p, input logic pe, input logic pt,
                            input logic s2, input logic pbit, input logic [1:0] stops,
                            input int unsigned gap);
    logic        q[$];
    int unsigned bitp;
    int          first_stop;
    bitp = ((p == 0) ? 1 : p) * OS;
    prescale = PW'(p);
    par_en = pe; par_typ = pt; stop2 = s2;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pe) q.push_back(pbit);
    first_stop = q.size();
    q.push_back(stops[0]);
    if (s2) q.push_back(stops[1]);
    for (int i = 0; i < q.size(); i++) begin
      rx = q[i];
      if (i == first_stop) stop_cyc = cyc;
      if (i == 1) begin
        prescale = PW'($urandom);
        par_en   = 1'($urandom);
        par_typ  = 1'($urandom);
        stop2    = 1'($urandom);
      end
      repeat (bitp) @(negedge clk);
    end
    if (gap > 0) begin
      rx = 1'b1;
      repeat (gap * bitp) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0; rx = 1'b1; ready = 1'b1;
    prescale = PW'(4); par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data); end
    total++; if (err !== 3'b000) begin bad++; $display("FAIL reset_err got=%b exp=000", err); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
    arst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int unsigned lat;
    got_q.delete(); got_cyc_q.delete(); mon_en = 1'b1; ready = 1'b1;
    send_frame(8'hA5, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 0);
    repeat (8) @(negedge clk);
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL basic_count got=%0d exp=1", got_q.size());
    end else begin
      total++;
      if (got_q[0] !== {8'hA5, 3'b000}) begin
        bad++; $display("FAIL basic_word got=%h exp=%h", got_q[0], {8'hA5, 3'b000});
      end
      lat = got_cyc_q[0] - stop_cyc;
      total++;
      if (lat < 32 || lat > 48) begin
        bad++; $display("FAIL basic_latency got=%0d exp=32..48 clocks into stop bit", lat);
      end
    end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL basic_active_end got=%b exp=0", active); end
  endtask

  task automatic test_parity();
    logic [10:0] exp[4];
    exp[0] = {8'hA5, 3'b001}; exp[1] = {8'hA5, 3'b000};
    exp[2] = {8'h07, 3'b000}; exp[3] = {8'h07, 3'b001};
    got_q.delete(); got_cyc_q.delete();
    send_frame(8'hA5, 4, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 0);
    send_frame(8'hA5, 4, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 0);
    send_frame(8'h07, 4, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 0);
    send_frame(8'h07, 4, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 1);
    total++;
    if (got_q.size() != 4) begin
      bad++; $display("FAIL parity_count got=%0d exp=4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (got_q[i] !== exp[i]) begin bad++; $display("FAIL parity_word[%0d] got=%h exp=%h", i, got_q[i], exp[i]); end
      end
    end
  endtask

  task automatic test_stop2();
    got_q.delete(); got_cyc_q.delete();
    send_frame(8'h81, 4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1);
    send_frame(8'h3C, 4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 1);
    total++;
    if (got_q.size() != 2) begin
      bad++; $display("FAIL stop2_count got=%0d exp=2", got_q.size());
    end else begin
      total++; if (got_q[0] !== {8'h81, 3'b010}) begin bad++; $display("FAIL stop2_bad got=%h exp=%h", got_q[0], {8'h81, 3'b010}); end
      total++; if (got_q[1] !== {8'h3C, 3'b000}) begin bad++; $display("FAIL stop2_next got=%h exp=%h", got_q[1], {8'h3C, 3'b000}); end
    end
  endtask

  task automatic test_break();
    got_q.delete(); got_cyc_q.delete();
    send_frame(8'h00, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0);
    rx = 1'b0;
    repeat (2 * 64) @(negedge clk);
    total++; if (got_q.size() != 1) begin bad++; $display("FAIL break_held_low got=%0d words exp=1", got_q.size()); end
    rx = 1'b1;
    repeat (64) @(negedge clk);
    send_frame(8'h3C, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1);
    total++;
    if (got_q.size() != 2) begin
      bad++; $display("FAIL break_count got=%0d exp=2", got_q.size());
    end else begin
      total++; if (got_q[0] !== {8'h00, 3'b010}) begin bad++; $display("FAIL break_word got=%h exp=%h", got_q[0], {8'h00, 3'b010}); end
      total++; if (got_q[1] !== {8'h3C, 3'b000}) begin bad++; $display("FAIL break_next got=%h exp=%h", got_q[1], {8'h3C, 3'b000}); end
    end
  endtask

  task automatic test_overrun();
    mon_en = 1'b0; ready = 1'b0;
    send_frame(8'h11, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 0);
    total++; if ({valid, data, err} !== {1'b1, 8'h11, 3'b000}) begin
      bad++; $display("FAIL ovr_first got=%b/%h/%b exp=1/11/000", valid, data, err); end
    send_frame(8'h22, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 0);
    total++; if ({valid, data, err} !== {1'b1, 8'h22, 3'b100}) begin
      bad++; $display("FAIL ovr_second got=%b/%h/%b exp=1/22/100", valid, data, err); end
    ready = 1'b1;
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL ovr_drop got=%b exp=0", valid); end
    repeat (16) @(negedge clk);
  endtask

  task automatic test_glitch();
    int act_cnt;
    act_cnt = 0;
    got_q.delete(); got_cyc_q.delete(); mon_en = 1'b1; ready = 1'b1;
    prescale = PW'(4);
    rx = 1'b0;
    repeat (16) begin @(negedge clk); if (active) act_cnt++; end
    rx = 1'b1;
    repeat (3 * 64) begin @(negedge clk); if (active) act_cnt++; end
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL glitch_valid got=%0d words exp=0", got_q.size()); end
    total++; if (act_cnt == 0) begin bad++; $display("FAIL glitch_active_seen got=0 cycles exp=>0"); end
    total++; if (act_cnt > 64) begin bad++; $display("FAIL glitch_active_len got=%0d cycles exp=<=64", act_cnt); end
    total++; if (active !== 1'b0) begin bad++; $display("FAIL glitch_active_end got=%b exp=0", active); end
  endtask

  task automatic test_reset_mid();
    mon_en = 1'b0; ready = 1'b0;
    send_frame(8'hC3, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 0);
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid got=%b exp=1", valid); end
    rx = 1'b0; repeat (64) @(negedge clk);
    rx = 1'b1; repeat (64) @(negedge clk);
    rx = 1'b0; repeat (64) @(negedge clk);
    rx = 1'b1; repeat (30) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    total++; if ({valid, data, err, active} !== 13'd0) begin
      bad++; $display("FAIL rstmid_outputs got=%b/%h/%b/%b exp=0/00/000/0", valid, data, err, active); end
    rx = 1'b1; ready = 1'b1;
    repeat (4) @(negedge clk);
    arst_n = 1'b1;
    repeat (8) @(negedge clk);
    got_q.delete(); got_cyc_q.delete(); mon_en = 1'b1;
    send_frame(8'h5A, 4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1);
    total++;
    if (got_q.size() != 1) begin
      bad++; $display("FAIL rstmid_count got=%0d exp=1", got_q.size());
    end else begin
      total++; if (got_q[0] !== {8'h5A, 3'b000}) begin bad++; $display("FAIL rstmid_word got=%h exp=%h", got_q[0], {8'h5A, 3'b000}); end
    end
  endtask

  task automatic test_random();
    logic [10:0] exp_q[$];
    logic [7:0]  d;
    logic        pe, pt, s2, pbit;
    logic [1:0]  stops;
    int unsigned p, gap;
    got_q.delete(); got_cyc_q.delete(); mon_en = 1'b1; ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom);
      p  = $urandom_range(0, 5);
      pe = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
      pbit = good_par(d, pt) ^ ($urandom_range(0, 3) == 0);
      stops = 2'b11;
      if ($urandom_range(0, 4) == 0) stops[0] = 1'b0;
      if ($urandom_range(0, 4) == 0) stops[1] = 1'b0;
      gap = ((s2 ? stops[1] : stops[0]) == 1'b0) ? 1 : (($urandom_range(0, 3) == 0) ? 1 : 0);
      exp_q.push_back(ref_word(d, pe, pt, pbit, s2, stops, 1'b0));
      send_frame(d, p, pe, pt, s2, pbit, stops, gap);
    end
    repeat (16) @(negedge clk);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_word[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_break();
    test_overrun();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
